flash_write_guard: RTL and testbench
====================================

Name: flash_write_guard

Overview:
- Gatekeeper between CPU writes in the $8000-$FFFF ROM window and the flash WE strobe.
- Tracks the JEDEC command sequences (unlock, program, sector/chip erase, reset) as the CPU issues them cycle by cycle.
- Passes only the writes that belong to a well-formed sequence; all other ROM-window writes are blocked.
- Its allow output replaces the static write-enable term in the top-level flash_we equation, so stray mapper-register writes can never corrupt flash.

Parameters:
- UNLOCK_ADDR_BITS, 11: number of low CPU address bits compared against the unlock addresses.
- ADDR_A, 11'h555: first and third unlock address.
- ADDR_B, 11'h2AA: second unlock address.
- BUSY_CYCLES, 16'd4096: m2 cycles for which the busy output stays high after a program or erase command completes.

Ports:
- m2  input  1  CPU M2; the only clock; all flops update on its falling edge, when write data is valid.
- reset  input  1  synchronous, active-high reset.
- guard_en  input  1  1 = enforce sequences; 0 = all ROM writes allowed (legacy behaviour).
- romsel  input  1  CPU /ROMSEL, active low.
- cpu_rw_in  input  1  1 = read, 0 = write.
- cpu_addr_in  input  15  CPU A14..A0.
- cpu_data_in  input  8  CPU data bus.
- we_allow  output  1  combinational; 1 = pass the current ROM write to flash.
- busy  output  1  program/erase timeout window active.
- cmd_done  output  1  one-cycle pulse when a program or erase command byte is accepted.
- violation  output  1  one-cycle pulse when a ROM write is blocked.
- state_dbg  output  4  current state encoding.

Behaviour:
- Definitions:
  - rom_wr = ~romsel & ~cpu_rw_in.
  - matchA = (cpu_addr_in[UNLOCK_ADDR_BITS-1:0] == ADDR_A); matchB is the same comparison against ADDR_B.
  - Only rom_wr cycles advance the state machine; reads and non-ROM cycles hold state.
- States: IDLE, U1, U2, PROG, E_U0, E_U1, E_U2.
- Transitions (on rom_wr at the falling edge of m2):
  - IDLE: AA@A -> U1.
  - U1: 55@B -> U2.
  - U2: A0@A -> PROG; 80@A -> E_U0; F0 at any address -> IDLE.
  - PROG: any address/data -> IDLE; pulse cmd_done; load busy counter.
  - E_U0: AA@A -> E_U1.
  - E_U1: 55@B -> E_U2.
  - E_U2: 30 at any address (sector erase) or 10@A (chip erase) -> IDLE; pulse cmd_done; load busy counter.
  - Any rom_wr that does not match the expected step -> IDLE. That write is not allowed; violation pulses. Exception: data F0 is always allowed, returns to IDLE and does not pulse violation.
- we_allow:
  - Equals 1 when guard_en = 0.
  - Otherwise it is a combinational function of state and address only (data is not yet valid when WE falls):
    - IDLE, U2, E_U0: matchA.
    - U1, E_U1: matchB.
    - PROG, E_U2: 1.
  - we_allow is not gated by rom_wr; the top level ANDs it with its own strobe.
- Address-allowed, data-wrong case: flash receives the byte and aborts on its own. The guard returns to IDLE and does not pulse violation, because the write reached flash.
- busy counter:
  - 16 bits; loaded with BUSY_CYCLES on cmd_done; decrements each cycle while nonzero.
  - busy = (counter != 0).
  - A new sequence during busy is still tracked; a new cmd_done reloads the counter (no accumulation).
- guard_en = 0: state is forced to IDLE each cycle and violation stays 0. The busy counter keeps running.
- Reset (mid-sequence included): state = IDLE, counter = 0, cmd_done = 0, violation = 0, busy = 0, state_dbg = 0.
  - During reset, we_allow = 0 regardless of guard_en.
- Latency:
  - State, cmd_done and violation update at the falling edge of m2 that ends the write cycle.
  - cmd_done and violation are high for exactly the following m2 cycle.

Decomposition:
- Shared package flash_guard_pkg holds:
  - the state enum and its 4-bit encoding;
  - command-byte constants CMD_UNLOCK1 = AA, CMD_UNLOCK2 = 55, CMD_PROG = A0, CMD_ERASE = 80, CMD_SECTOR = 30, CMD_CHIP = 10, CMD_RESET = F0.
- One sub-module: flash_busy_timer (loadable down-counter with nonzero flag).
- The sequence FSM stays in the top module.

Test Plan:
- Program: guard_en = 1; write AA@$8555, 55@$82AA, A0@$8555, 3C@$9123 -> we_allow = 1 on all four; cmd_done pulses after the 4th; busy high for exactly 4096 cycles.
- Stray write: write 07@$8000 in IDLE -> we_allow = 0, violation pulses once, state stays IDLE.
- Sector erase: AA@555, 55@2AA, 80@555, AA@555, 55@2AA, 30@$A000 -> all six allowed; cmd_done pulses once; state returns to IDLE.
- Broken sequence: AA@555 then 55@$8100 -> second write blocked, violation pulses, state IDLE; a following AA@555 moves to U1.
- Reset during sequence: reset asserted in PROG -> next cycle state_dbg = 0; a write to $9000 is blocked; busy = 0.
- Legacy mode: guard_en = 0 -> write to $C000 gives we_allow = 1, violation = 0; interleaved reads do not change state.

Source files
------------

// File: rtl/flash_guard_pkg.sv
// Shared definitions for the flash write guard: state encoding and JEDEC command bytes.
package flash_guard_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_U1   = 4'd1,
        ST_U2   = 4'd2,
        ST_PROG = 4'd3,
        ST_E_U0 = 4'd4,
        ST_E_U1 = 4'd5,
        ST_E_U2 = 4'd6
    } guard_state_t;

    localparam logic [7:0] CMD_UNLOCK1 = 8'hAA;
    localparam logic [7:0] CMD_UNLOCK2 = 8'h55;
    localparam logic [7:0] CMD_PROG    = 8'hA0;
    localparam logic [7:0] CMD_ERASE   = 8'h80;
    localparam logic [7:0] CMD_SECTOR  = 8'h30;
    localparam logic [7:0] CMD_CHIP    = 8'h10;
    localparam logic [7:0] CMD_RESET   = 8'hF0;

endpackage

// File: rtl/flash_busy_timer.sv
// Loadable down-counter that flags the program/erase timeout window while nonzero.
module flash_busy_timer #(
    parameter int unsigned     WIDTH      = 16,
    parameter logic [WIDTH-1:0] LOAD_VALUE = 16'd4096
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy
);

    logic [WIDTH-1:0] count;

    // Reload on each accepted command (no accumulation), otherwise count down to zero.
    always_ff @(negedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/flash_write_guard.sv
// Gates CPU writes in the ROM window so only well-formed JEDEC command sequences reach flash WE.
module flash_write_guard
    import flash_guard_pkg::*;
#(
    parameter int unsigned                  UNLOCK_ADDR_BITS = 11,
    parameter logic [UNLOCK_ADDR_BITS-1:0]  ADDR_A           = 11'h555,
    parameter logic [UNLOCK_ADDR_BITS-1:0]  ADDR_B           = 11'h2AA,
    parameter logic [15:0]                  BUSY_CYCLES      = 16'd4096
) (
    input  logic        m2,
    input  logic        reset,
    input  logic        guard_en,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    output logic        we_allow,
    output logic        busy,
    output logic        cmd_done,
    output logic        violation,
    output logic [3:0]  state_dbg
);

    guard_state_t state, state_next;
    logic         rom_wr;
    logic         match_a, match_b;
    logic         addr_ok;
    logic         cmd_accept;
    logic         viol_next;
    logic         unused_addr_hi;

    assign rom_wr         = ~romsel & ~cpu_rw_in;
    assign match_a        = (cpu_addr_in[UNLOCK_ADDR_BITS-1:0] == ADDR_A);
    assign match_b        = (cpu_addr_in[UNLOCK_ADDR_BITS-1:0] == ADDR_B);
    assign unused_addr_hi = ^cpu_addr_in[14:UNLOCK_ADDR_BITS];

    // Address-only write permission per state; data is not yet valid when WE falls.
    always_comb begin
        addr_ok = 1'b0;
        case (state)
            ST_IDLE, ST_U2, ST_E_U0: addr_ok = match_a;
            ST_U1, ST_E_U1:          addr_ok = match_b;
            ST_PROG, ST_E_U2:        addr_ok = 1'b1;
            default:                 addr_ok = 1'b0;
        endcase
        we_allow = ~reset & (~guard_en | addr_ok);
    end

    // Sequence tracking: a ROM write either advances the expected step or drops back to IDLE.
    always_comb begin
        state_next = state;
        cmd_accept = 1'b0;
        viol_next  = 1'b0;
        if (!guard_en) begin
            state_next = ST_IDLE;
        end else if (rom_wr) begin
            state_next = ST_IDLE;
            case (state)
                ST_IDLE: if (match_a && cpu_data_in == CMD_UNLOCK1) state_next = ST_U1;
                ST_U1:   if (match_b && cpu_data_in == CMD_UNLOCK2) state_next = ST_U2;
                ST_U2: begin
                    if (match_a && cpu_data_in == CMD_PROG)       state_next = ST_PROG;
                    else if (match_a && cpu_data_in == CMD_ERASE) state_next = ST_E_U0;
                end
                ST_PROG: cmd_accept = 1'b1;
                ST_E_U0: if (match_a && cpu_data_in == CMD_UNLOCK1) state_next = ST_E_U1;
                ST_E_U1: if (match_b && cpu_data_in == CMD_UNLOCK2) state_next = ST_E_U2;
                ST_E_U2: begin
                    if (cpu_data_in == CMD_SECTOR || (match_a && cpu_data_in == CMD_CHIP))
                        cmd_accept = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
            // Only writes that never reached flash count as violations; F0 is always benign.
            if (!addr_ok && cpu_data_in != CMD_RESET) viol_next = 1'b1;
        end
    end

    // State and single-cycle status pulses, updated when write data is valid.
    always_ff @(negedge m2) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_done  <= 1'b0;
            violation <= 1'b0;
        end else begin
            state     <= state_next;
            cmd_done  <= cmd_accept;
            violation <= viol_next;
        end
    end

    assign state_dbg = state;

    flash_busy_timer #(
        .WIDTH      (16),
        .LOAD_VALUE (BUSY_CYCLES)
    ) u_busy_timer (
        .clk   (m2),
        .reset (reset),
        .load  (cmd_accept),
        .busy  (busy)
    );

endmodule

// File: tb/tb_flash_write_guard.sv
// Scoreboard bench for flash_write_guard: expected post-edge results are queued at drive time.
module tb_flash_write_guard;

    logic        m2 = 1'b0;
    logic        reset;
    logic        guard_en;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        we_allow;
    logic        busy;
    logic        cmd_done;
    logic        violation;
    logic [3:0]  state_dbg;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic       cmd;
        logic       viol;
    } exp_t;

    exp_t exp_q[$];

    flash_write_guard #(
        .UNLOCK_ADDR_BITS (11),
        .ADDR_A           (11'h555),
        .ADDR_B           (11'h2AA),
        .BUSY_CYCLES      (16'd4096)
    ) dut (
        .m2          (m2),
        .reset       (reset),
        .guard_en    (guard_en),
        .romsel      (romsel),
        .cpu_rw_in   (cpu_rw_in),
        .cpu_addr_in (cpu_addr_in),
        .cpu_data_in (cpu_data_in),
        .we_allow    (we_allow),
        .busy        (busy),
        .cmd_done    (cmd_done),
        .violation   (violation),
        .state_dbg   (state_dbg)
    );

    always #5 m2 = ~m2;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive while m2 is high, check we_allow before the falling edge,
    // then compare registered results popped from the scoreboard just after it.
    task automatic bus_cycle(input logic rs, input logic rd, input logic [14:0] a,
                             input logic [7:0] d, input logic chk_allow, input logic exp_allow,
                             input logic [3:0] exp_st, input logic exp_cmd, input logic exp_viol,
                             input string tag);
        exp_t e;
        @(posedge m2); #1;
        romsel = rs; cpu_rw_in = rd; cpu_addr_in = a; cpu_data_in = d;
        #1;
        if (chk_allow) check_val({tag, "/allow"}, 16'(we_allow), 16'(exp_allow));
        exp_q.push_back('{tag, exp_st, exp_cmd, exp_viol});
        @(negedge m2); #1;
        e = exp_q.pop_front();
        check_val({e.tag, "/state"}, 16'(state_dbg), 16'(e.st));
        check_val({e.tag, "/cmd"},   16'(cmd_done),  16'(e.cmd));
        check_val({e.tag, "/viol"},  16'(violation), 16'(e.viol));
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d, input logic allow,
                      input logic [3:0] st, input logic cmd, input logic viol, input string tag);
        bus_cycle(1'b0, 1'b0, a, d, 1'b1, allow, st, cmd, viol, tag);
    endtask

    task automatic idle(input logic [3:0] st, input string tag);
        bus_cycle(1'b1, 1'b1, 15'h0, 8'h00, 1'b0, 1'b0, st, 1'b0, 1'b0, tag);
    endtask

    task automatic step();
        @(posedge m2); #1;
        romsel = 1'b1; cpu_rw_in = 1'b1;
        @(negedge m2); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; guard_en = 1'b0; romsel = 1'b1; cpu_rw_in = 1'b1;
        cpu_addr_in = '0; cpu_data_in = '0;

        // Reset: we_allow forced low even in legacy mode
        @(posedge m2); #1;
        romsel = 1'b0; cpu_rw_in = 1'b0; cpu_addr_in = 15'h0555;
        #1 check_val("rst_allow_legacy", 16'(we_allow), 16'd0);
        guard_en = 1'b1;
        #1 check_val("rst_allow_guard", 16'(we_allow), 16'd0);
        @(negedge m2); #1;
        check_val("rst_state", 16'(state_dbg), 16'd0);
        check_val("rst_busy",  16'(busy),      16'd0);
        check_val("rst_cmd",   16'(cmd_done),  16'd0);
        check_val("rst_viol",  16'(violation), 16'd0);
        @(posedge m2); #1;
        reset = 1'b0; romsel = 1'b1; cpu_rw_in = 1'b1;

        // Program sequence and busy window length
        wr(15'h0555, 8'hAA, 1'b1, 4'd1, 1'b0, 1'b0, "prog1");
        wr(15'h02AA, 8'h55, 1'b1, 4'd2, 1'b0, 1'b0, "prog2");
        wr(15'h0555, 8'hA0, 1'b1, 4'd3, 1'b0, 1'b0, "prog3");
        wr(15'h1123, 8'h3C, 1'b1, 4'd0, 1'b1, 1'b0, "prog4");
        check_val("prog_busy_start", 16'(busy), 16'd1);
        n = 1;
        for (int i = 0; i < 5000 && busy; i++) begin
            step();
            if (busy) n++;
        end
        check_val("prog_busy_len", 16'(n), 16'd4096);
        check_val("prog_cmd_clear", 16'(cmd_done), 16'd0);

        // Stray write in IDLE
        wr(15'h0000, 8'h07, 1'b0, 4'd0, 1'b0, 1'b1, "stray");
        idle(4'd0, "stray_after");

        // Sector erase
        wr(15'h0555, 8'hAA, 1'b1, 4'd1, 1'b0, 1'b0, "se1");
        wr(15'h02AA, 8'h55, 1'b1, 4'd2, 1'b0, 1'b0, "se2");
        wr(15'h0555, 8'h80, 1'b1, 4'd4, 1'b0, 1'b0, "se3");
        wr(15'h0555, 8'hAA, 1'b1, 4'd5, 1'b0, 1'b0, "se4");
        wr(15'h02AA, 8'h55, 1'b1, 4'd6, 1'b0, 1'b0, "se5");
        wr(15'h2000, 8'h30, 1'b1, 4'd0, 1'b1, 1'b0, "se6");
        idle(4'd0, "se_after");
        check_val("se_busy", 16'(busy), 16'd1);

        // Chip erase, with an address-allowed wrong byte first in E_U2
        wr(15'h0555, 8'hAA, 1'b1, 4'd1, 1'b0, 1'b0, "ce1");
        wr(15'h02AA, 8'h55, 1'b1, 4'd2, 1'b0, 1'b0, "ce2");
        wr(15'h0555, 8'h80, 1'b1, 4'd4, 1'b0, 1'b0, "ce3");
        wr(15'h0555, 8'hAA, 1'b1, 4'd5, 1'b0, 1'b0, "ce4");
        wr(15'h02AA, 8'h55, 1'b1, 4'd6, 1'b0, 1'b0, "ce5");
        wr(15'h0123, 8'h10, 1'b1, 4'd0, 1'b0, 1'b0, "ce_badaddr");
        wr(15'h0555, 8'hAA, 1'b1, 4'd1, 1'b0, 1'b0, "ce1b");
        wr(15'h02AA, 8'h55, 1'b1, 4'd2, 1'b0, 1'b0, "ce2b");
        wr(15'h0555, 8'h80, 1'b1, 4'd4, 1'b0, 1'b0, "ce3b");
        wr(15'h0555, 8'hAA, 1'b1, 4'd5, 1'b0, 1'b0, "ce4b");
        wr(15'h02AA, 8'h55, 1'b1, 4'd6, 1'b0, 1'b0, "ce5b");
        wr(15'h0555, 8'h10, 1'b1, 4'd0, 1'b1, 1'b0, "ce6");

        // Broken sequence, then recovery
        wr(15'h0555, 8'hAA, 1'b1, 4'd1, 1'b0, 1'b0, "brk1");
        wr(15'h0100, 8'h55, 1'b0, 4'd0, 1'b0, 1'b1, "brk2");
        wr(15'h0555, 8'hAA, 1'b1, 4'd1, 1'b0, 1'b0, "brk3");

        // F0 at a blocked address: back to IDLE with no violation
        wr(15'h0100, 8'hF0, 1'b0, 4'd0, 1'b0, 1'b0, "f0_reset");
        // Allowed address, wrong data: no violation
        wr(15'h0555, 8'h12, 1'b1, 4'd0, 1'b0, 1'b0, "datawrong");

        // Reads and non-ROM writes hold state
        wr(15'h0555, 8'hAA, 1'b1, 4'd1, 1'b0, 1'b0, "hold1");
        bus_cycle(1'b0, 1'b1, 15'h0100, 8'h00, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, "hold_read");
        bus_cycle(1'b1, 1'b0, 15'h0100, 8'h00, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, "hold_nonrom");
        wr(15'h02AA, 8'h55, 1'b1, 4'd2, 1'b0, 1'b0, "hold2");
        wr(15'h0555, 8'hA0, 1'b1, 4'd3, 1'b0, 1'b0, "hold3");

        // Reset while in PROG
        check_val("pre_rst_busy", 16'(busy), 16'd1);
        @(posedge m2); #1;
        reset = 1'b1; romsel = 1'b0; cpu_rw_in = 1'b0; cpu_addr_in = 15'h1000;
        #1 check_val("mid_rst_allow", 16'(we_allow), 16'd0);
        @(negedge m2); #1;
        check_val("mid_rst_state", 16'(state_dbg), 16'd0);
        check_val("mid_rst_busy",  16'(busy),      16'd0);
        check_val("mid_rst_cmd",   16'(cmd_done),  16'd0);
        @(posedge m2); #1;
        reset = 1'b0; romsel = 1'b1; cpu_rw_in = 1'b1;
        wr(15'h1000, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, "post_rst_wr");

        // Legacy mode
        @(posedge m2); #1 guard_en = 1'b0;
        wr(15'h4000, 8'h12, 1'b1, 4'd0, 1'b0, 1'b0, "leg_wr");
        wr(15'h0555, 8'hAA, 1'b1, 4'd0, 1'b0, 1'b0, "leg_unlock");
        bus_cycle(1'b0, 1'b1, 15'h4000, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "leg_read");
        wr(15'h0100, 8'h07, 1'b1, 4'd0, 1'b0, 1'b0, "leg_stray");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
